// File: rtl/dice_display.sv
// Display stage for the electronic dice: blinking live view while rolling, then settle, latch, validate and show pips.
// Optional build macro DICE_DISPLAY_HIST_EN adds a 4-deep history of legal faces on output hist.
module dice_display #(
  parameter int SETTLE_CYCLES = 2,
  parameter int BLINK_DIV     = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             button,
  input  logic [2:0]       throw,
  output logic [6:0]       pips,
  output logic [2:0]       face,
  output logic             valid,
  output logic             rolling,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] throw_count
`ifdef DICE_DISPLAY_HIST_EN
  ,
  output logic [11:0]      hist
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ROLL   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_SHOW   = 2'd3;

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_DIV - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  logic [1:0]       r_state;
  logic [BW-1:0]    r_blink_cnt;
  logic             r_phase;
  logic [SW-1:0]    r_settle_cnt;
  logic [6:0]       r_pips;
  logic [2:0]       r_face;
  logic             r_valid;
  logic             r_rolling;
  logic             r_done;
  logic             r_err;
  logic [CNT_W-1:0] r_count;

  logic             w_blink_wrap;
  logic [BW-1:0]    w_blink_cnt_nxt;
  logic             w_phase_nxt;
  logic [6:0]       w_live_pips;
  logic             w_legal;
  logic             w_sample;

  function automatic logic [6:0] pip_map(input logic [2:0] v);
    case (v)
      3'd1:    pip_map = 7'h08;
      3'd2:    pip_map = 7'h41;
      3'd3:    pip_map = 7'h49;
      3'd4:    pip_map = 7'h63;
      3'd5:    pip_map = 7'h6B;
      3'd6:    pip_map = 7'h77;
      default: pip_map = 7'h00;
    endcase
  endfunction

  // Blink advances on every ROLL/SETTLE edge; pips register takes the phase that will hold after this edge.
  assign w_blink_wrap    = (r_blink_cnt == BLINK_LAST);
  assign w_blink_cnt_nxt = w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
  assign w_phase_nxt     = w_blink_wrap ? ~r_phase : r_phase;
  assign w_live_pips     = w_phase_nxt ? pip_map(throw) : 7'h00;

  assign w_legal  = (throw != 3'd0) && (throw != 3'd7);
  assign w_sample = (r_state == S_SETTLE) && !button && (r_settle_cnt == SETTLE_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: every register here is cleared by the synchronous reset; nothing is left to power-up values.
    if (reset) begin
      r_state      <= S_IDLE;
      r_blink_cnt  <= '0;
      r_phase      <= 1'b0;
      r_settle_cnt <= '0;
      r_pips       <= 7'h00;
      r_face       <= 3'd0;
      r_valid      <= 1'b0;
      r_rolling    <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_count      <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (button) begin
            r_state     <= S_ROLL;
            r_rolling   <= 1'b1;
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
            r_pips      <= pip_map(throw);
          end else begin
            r_rolling <= 1'b0;
            r_pips    <= 7'h00;
          end
        end

        S_ROLL: begin
          r_rolling   <= 1'b1;
          r_valid     <= 1'b0;
          r_blink_cnt <= w_blink_cnt_nxt;
          r_phase     <= w_phase_nxt;
          r_pips      <= w_live_pips;
          if (!button) begin
            r_state      <= S_SETTLE;
            r_settle_cnt <= '0;
          end
        end

        S_SETTLE: begin
          if (button) begin
            r_state      <= S_ROLL;
            r_settle_cnt <= '0;
            r_blink_cnt  <= w_blink_cnt_nxt;
            r_phase      <= w_phase_nxt;
            r_pips       <= w_live_pips;
          end else if (w_sample) begin
            r_rolling <= 1'b0;
            if (w_legal) begin
              r_state <= S_SHOW;
              r_face  <= throw;
              r_pips  <= pip_map(throw);
              r_valid <= 1'b1;
              r_done  <= 1'b1;
              if (r_count != {CNT_W{1'b1}}) r_count <= r_count + 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_face  <= 3'd0;
              r_pips  <= 7'h00;
              r_valid <= 1'b0;
              r_err   <= 1'b1;
            end
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
            r_blink_cnt  <= w_blink_cnt_nxt;
            r_phase      <= w_phase_nxt;
            r_pips       <= w_live_pips;
          end
        end

        default: begin
          r_rolling <= 1'b0;
          // Face stays on display until the next latch; only valid drops on a new press.
          if (button) begin
            r_state     <= S_ROLL;
            r_rolling   <= 1'b1;
            r_valid     <= 1'b0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
            r_pips      <= pip_map(throw);
          end
        end
      endcase
    end
  end

`ifdef DICE_DISPLAY_HIST_EN
  logic [11:0] r_hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist <= 12'h000;
    end else if (w_sample && w_legal) begin
      r_hist <= {r_hist[8:0], throw};
    end
  end

  assign hist = r_hist;
`endif

  assert property (@(posedge clk) disable iff (reset) !(r_done && r_err));
  assert property (@(posedge clk) disable iff (reset) (r_done || r_err) |=> !(r_done || r_err));

  assign pips        = r_pips;
  assign face        = r_face;
  assign valid       = r_valid;
  assign rolling     = r_rolling;
  assign done        = r_done;
  assign err         = r_err;
  assign throw_count = r_count;

endmodule

// File: tb/tb_dice_display.sv
// Scoreboard bench for dice_display: stimulus pushes expected latch/error events, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_dice_display;

  logic       clk = 1'b0;
  logic       reset;
  logic       button;
  logic [2:0] throw;

  logic [6:0] pips,  s_pips;
  logic [2:0] face,  s_face;
  logic       valid, s_valid;
  logic       rolling, s_rolling;
  logic       done,  s_done;
  logic       err,   s_err;
  logic [7:0] throw_count;
  logic [1:0] sat_count;
`ifdef DICE_DISPLAY_HIST_EN
  logic [11:0] hist, s_hist;
`endif

  always #5 clk = ~clk;

  dice_display #(.SETTLE_CYCLES(2), .BLINK_DIV(4), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .button(button), .throw(throw),
    .pips(pips), .face(face), .valid(valid), .rolling(rolling),
    .done(done), .err(err), .throw_count(throw_count)
`ifdef DICE_DISPLAY_HIST_EN
    , .hist(hist)
`endif
  );

  dice_display #(.SETTLE_CYCLES(2), .BLINK_DIV(4), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .button(button), .throw(throw),
    .pips(s_pips), .face(s_face), .valid(s_valid), .rolling(s_rolling),
    .done(s_done), .err(s_err), .throw_count(sat_count)
`ifdef DICE_DISPLAY_HIST_EN
    , .hist(s_hist)
`endif
  );

  typedef struct {
    logic        is_err;
    logic [2:0]  face;
    logic [6:0]  pips;
    logic [7:0]  cnt;
    logic [1:0]  sat_cnt;
    logic [11:0] hist;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  m_cnt;
  logic [1:0]  m_sat;
  logic [11:0] m_hist;

  function automatic logic [6:0] exp_pips(input logic [2:0] v);
    case (v)
      3'd1:    exp_pips = 7'h08;
      3'd2:    exp_pips = 7'h41;
      3'd3:    exp_pips = 7'h49;
      3'd4:    exp_pips = 7'h63;
      3'd5:    exp_pips = 7'h6B;
      3'd6:    exp_pips = 7'h77;
      default: exp_pips = 7'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_legal(input logic [2:0] f);
    exp_t e;
    m_cnt  = m_cnt + 8'd1;
    m_sat  = (m_sat == 2'd3) ? 2'd3 : m_sat + 2'd1;
    m_hist = {m_hist[8:0], f};
    e.is_err = 1'b0; e.face = f; e.pips = exp_pips(f);
    e.cnt = m_cnt; e.sat_cnt = m_sat; e.hist = m_hist;
    sb.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1; e.face = 3'd0; e.pips = 7'h00;
    e.cnt = m_cnt; e.sat_cnt = m_sat; e.hist = m_hist;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (sb.size() != 0 && n < budget);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every done/err pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && (done || err)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'({done, err}), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_err",   32'(err),         32'(mon_e.is_err));
        check("pulse_done",  32'(done),        32'(!mon_e.is_err));
        check("pulse_face",  32'(face),        32'(mon_e.face));
        check("pulse_pips",  32'(pips),        32'(mon_e.pips));
        check("pulse_valid", 32'(valid),       32'(!mon_e.is_err));
        check("pulse_count", 32'(throw_count), 32'(mon_e.cnt));
        check("sat_done",    32'(s_done),      32'(done));
        check("sat_count",   32'(sat_count),   32'(mon_e.sat_cnt));
`ifdef DICE_DISPLAY_HIST_EN
        check("pulse_hist",  32'(hist),        32'(mon_e.hist));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; button = 1'b0; throw = 3'd0;
    m_cnt = 8'd0; m_sat = 2'd0; m_hist = 12'h000;
    tick(); tick();
    check("rst_pips",    32'(pips),        32'd0);
    check("rst_face",    32'(face),        32'd0);
    check("rst_valid",   32'(valid),       32'd0);
    check("rst_rolling", 32'(rolling),     32'd0);
    check("rst_done",    32'(done),        32'd0);
    check("rst_err",     32'(err),         32'd0);
    check("rst_count",   32'(throw_count), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_rolling", 32'(rolling), 32'd0);

    // Hold button 10 cycles with throw cycling 1..6: on 4, off 4, on again.
    for (int i = 0; i < 10; i++) begin
      throw  = 3'((i % 6) + 1);
      button = 1'b1;
      tick();
      check("roll_rolling", 32'(rolling), 32'd1);
      check("roll_valid",   32'(valid),   32'd0);
      check("roll_blink",   32'(pips),    32'(((i / 4) % 2 == 0) ? exp_pips(throw) : 7'h00));
    end

    // Release with throw=5: latch exactly two edges after release.
    expect_legal(3'd5);
    button = 1'b0; throw = 3'd5;
    tick();
    check("settle_rolling", 32'(rolling), 32'd1);
    check("settle_blink",   32'(pips),    32'(exp_pips(3'd5)));
    tick();
    check("early_done",  32'(done),  32'd0);
    check("early_valid", 32'(valid), 32'd0);
    tick();
    check("latency_valid", 32'(valid), 32'd1);
    check("latency_done",  32'(done),  32'd1);
    drain(4);
    tick();
    check("done_one_cycle", 32'(done),    32'd0);
    check("show_valid",     32'(valid),   32'd1);
    check("show_rolling",   32'(rolling), 32'd0);

    // Illegal settled throw of 7.
    button = 1'b1; throw = 3'd7;
    tick();
    check("reroll_valid", 32'(valid), 32'd0);
    check("reroll_face",  32'(face),  32'd5);
    tick();
    expect_err();
    button = 1'b0;
    tick(); tick(); tick();
    check("err_pulse", 32'(err), 32'd1);
    drain(4);
    tick();
    check("err_one_cycle", 32'(err),         32'd0);
    check("err_idle_roll", 32'(rolling),     32'd0);
    check("err_idle_pips", 32'(pips),        32'd0);
    check("err_face",      32'(face),        32'd0);
    check("err_count",     32'(throw_count), 32'd1);

    // Re-press on the would-be sample edge: back to ROLL, nothing latched.
    button = 1'b1; throw = 3'd2;
    tick(); tick();
    button = 1'b0;
    tick(); tick();
    button = 1'b1;
    tick();
    check("repress_no_done", 32'(done),    32'd0);
    check("repress_rolling", 32'(rolling), 32'd1);
    check("repress_valid",   32'(valid),   32'd0);
    tick();
    expect_legal(3'd3);
    button = 1'b0; throw = 3'd3;
    tick(); tick();
    check("repress_early_valid", 32'(valid), 32'd0);
    tick();
    check("repress_latch", 32'(valid), 32'd1);
    drain(4);

    // Single-cycle glitch from SHOW still goes through a full settle.
    expect_legal(3'd4);
    button = 1'b1; throw = 3'd4;
    tick();
    check("glitch_face_kept", 32'(face),  32'd3);
    check("glitch_valid",     32'(valid), 32'd0);
    button = 1'b0;
    tick(); tick();
    check("glitch_no_early", 32'(valid), 32'd0);
    tick();
    check("glitch_latch", 32'(valid), 32'd1);
    drain(4);

    // Two more legal throws: the 2-bit counter saturates at 3.
    expect_legal(3'd6);
    button = 1'b1; throw = 3'd6;
    tick(); tick();
    button = 1'b0;
    repeat (3) tick();
    drain(8);
    expect_legal(3'd1);
    button = 1'b1; throw = 3'd1;
    tick(); tick();
    button = 1'b0;
    repeat (3) tick();
    drain(8);
    check("count_final", 32'(throw_count), 32'd5);
    check("sat_final",   32'(sat_count),   32'd3);
`ifdef DICE_DISPLAY_HIST_EN
    check("hist_final",  32'(hist),        32'h731);
`endif

    // Reset mid-SETTLE with button held.
    button = 1'b1; throw = 3'd2;
    tick();
    button = 1'b0;
    tick();
    check("pre_reset_settle", 32'(rolling), 32'd1);
    reset = 1'b1; button = 1'b1;
    tick();
    check("mid_rst_pips",    32'(pips),        32'd0);
    check("mid_rst_face",    32'(face),        32'd0);
    check("mid_rst_valid",   32'(valid),       32'd0);
    check("mid_rst_rolling", 32'(rolling),     32'd0);
    check("mid_rst_done",    32'(done),        32'd0);
    check("mid_rst_err",     32'(err),         32'd0);
    check("mid_rst_count",   32'(throw_count), 32'd0);
    check("mid_rst_sat",     32'(sat_count),   32'd0);
`ifdef DICE_DISPLAY_HIST_EN
    check("mid_rst_hist",    32'(hist),        32'd0);
`endif
    reset = 1'b0; button = 1'b0;
    tick();
    check("post_rst_idle", 32'(rolling), 32'd0);
    check("post_rst_pips", 32'(pips),    32'd0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dice_display.md
# dice_display

Downstream display stage for the electronic dice. Consumes the dice's `throw[2:0]` together with the same `button` the dice sees. While the button is held it shows a blinking live view of the rolling value. After release it waits for the dice to settle, latches the final face, validates it and drives a 7-LED pip pattern, a done pulse and a throw counter.

## Interface
- `SETTLE_CYCLES`, 2: cycles waited after button release before sampling `throw`; legal range ≥1.
- `BLINK_DIV`, 4: cycles per blink half-period while rolling; legal range ≥1.
- `CNT_W`, 8: width of the completed-throw counter.
- `clk`  in  1: single clock, all logic on posedge.
- `reset`  in  1: synchronous, active-high reset.
- `button`  in  1: roll button, same net that drives the dice.
- `throw`  in  3: dice output, legal values 1–6.
- `pips`  out  7: LED pattern. Bit0 TL, bit1 TR, bit2 ML, bit3 C, bit4 MR, bit5 BL, bit6 BR.
- `face`  out  3: latched result, 0 when none.
- `valid`  out  1: `face`/`pips` hold a settled result.
- `rolling`  out  1: high in ROLL and SETTLE.
- `done`  out  1: one-cycle pulse when a legal face is latched.
- `err`  out  1: one-cycle pulse when the settled `throw` is 0 or 7.
- `throw_count`  out  CNT_W: number of legal throws completed.

## Operation
- All outputs are registered. Reset forces the following regardless of state:
  - state IDLE
  - `pips`=0, `face`=0, `valid`=0, `rolling`=0, `done`=0, `err`=0, `throw_count`=0
  - blink and settle counters cleared
- Pip map:
  - 1 → 7'h08
  - 2 → 7'h41
  - 3 → 7'h49
  - 4 → 7'h63
  - 5 → 7'h6B
  - 6 → 7'h77
  - 0 and 7 → 7'h00
- FSM states are IDLE, ROLL, SETTLE, SHOW.
- IDLE:
  - `pips`=0, `valid`=0.
  - `button`=1 moves to ROLL; blink counter cleared and blink phase set to on.
- ROLL:
  - `rolling`=1, `valid`=0.
  - `pips` = map(`throw`) when phase is on, 0 when phase is off.
  - Phase toggles every BLINK_DIV cycles.
  - `button`=0 moves to SETTLE with the settle counter set to 0.
- SETTLE:
  - `rolling`=1; `pips` continues blinking.
  - `button`=1 returns to ROLL: counter cleared, no sample taken.
  - Otherwise, when the counter equals SETTLE_CYCLES-1, `throw` is sampled. If the counter is lower, it increments.
  - Sampled 1–6: `face`=throw, `pips`=map, `valid`=1, `done` pulse, `throw_count`+1, go to SHOW.
  - Sampled 0 or 7: `err` pulse, `face`=0, `pips`=0, `valid`=0, go to IDLE.
- SHOW:
  - Static `pips`; `face` and `valid` held.
  - `button`=1 moves to ROLL. `valid` drops and `face` is kept until the next latch.
- `throw_count` saturates at all-ones and never wraps.
- `done` and `err` are mutually exclusive and never high in consecutive cycles.
- If reset and button are both asserted, reset wins.

## Timing
- Button response: `button`=1 sampled at edge E moves the FSM to ROLL. `rolling`=1 from E until the next edge.
- In ROLL, `pips` reflects the `throw` value sampled at the previous edge (1-cycle lag).
- Release latency: `button`=0 first sampled at edge E0 (in ROLL). `throw` is sampled at edge E0+SETTLE_CYCLES. `valid`, `done` and `throw_count` update from that edge.
- Blink: phase on for the first BLINK_DIV cycles after entering ROLL, then alternates. A ROLL→SETTLE transition does not reset the phase.
- A single-cycle button glitch in IDLE or SHOW produces ROLL then SETTLE, and a full settle before the latch.

## Configuration
- Macro: `DICE_DISPLAY_HIST_EN`.
- Defined:
  - Adds output `hist[11:0]`, a shift register of the last four legal faces, newest in [2:0].
  - It shifts on each `done` and clears on reset.
  - Illegal throws are not recorded.
- Undefined: no `hist` port and no history registers. All other behaviour is identical.

## Test plan
- Reset, then hold `button` 10 cycles with `throw` cycling 1–6, BLINK_DIV=4:
  - `rolling`=1 throughout.
  - `pips` nonzero for 4 cycles, then 0 for 4 cycles.
  - `valid`=0.
- Release with `throw` held at 5, SETTLE_CYCLES=2:
  - Exactly 2 edges after release: `face`=5, `pips`=7'h6B, `valid`=1.
  - One-cycle `done`; `throw_count`=1.
- Release with `throw` forced to 7:
  - `err` pulses once.
  - FSM back in IDLE with `pips`=0 and `valid`=0; `throw_count` unchanged.
- Re-press `button` 1 cycle into SETTLE:
  - No `done`, no sample; FSM returns to ROLL.
  - On final release with `throw`=3, `face`=3 and `pips`=7'h49.
- CNT_W=2, five legal throws: `throw_count` ends at 3 (saturated).
- Assert `reset` mid-SETTLE with `button`=1:
  - Next cycle all outputs 0 and state IDLE.
  - With HIST_EN defined, `hist`=0.
